alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have port in_valid, input, 1 bit: upstream has an instruction with operands.
REQ-004 The module SHALL have port in_ready, output, 1 bit: block accepts the input this cycle.
REQ-005 The module SHALL have port instr, input, 32 bits: RV32I instruction word.
REQ-006 The module SHALL have port rs1_data, input, 32 bits: register-file value of rs1.
REQ-007 The module SHALL have port rs2_data, input, 32 bits: register-file value of rs2.
REQ-008 The module SHALL have port out_valid, output, 1 bit: head entry presented to the ALU.
REQ-009 The module SHALL have port out_ready, input, 1 bit: downstream consumes the head entry.
REQ-010 The module SHALL have port alu_a, output, 32 bits: ALU operand A.
REQ-011 The module SHALL have port alu_b, output, 32 bits: ALU operand B.
REQ-012 The module SHALL have port alu_op, output, 3 bits: ALU opcode.
REQ-013 The module SHALL have port rd, output, 5 bits: destination register.
REQ-014 The module SHALL have port illegal, output, 1 bit: head entry is not a supported ALU instruction.

Function
REQ-015 The ALU opcode encoding SHALL be fixed: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=101, SRL=110; 111 is never emitted.
REQ-016 Decode for opcode 0110011 SHALL map funct7/funct3 as follows: 0000000/000 ADD, 0100000/000 SUB, 0000000/111 AND, 0000000/110 OR, 0000000/100 XOR, 0000000/001 SLL, 0000000/101 SRL; operand B is rs2_data.
REQ-017 Decode for opcode 0010011 SHALL map funct3 as follows: 000 ADD, 111 AND, 110 OR, 100 XOR; operand B is instr[31:20] sign-extended to 32 bits.
REQ-018 Decode for opcode 0010011 SHALL also map funct3 001 with instr[31:25]=0000000 to SLL and funct3 101 with instr[31:25]=0000000 to SRL; operand B is {27'b0, instr[24:20]}.
REQ-019 Operand A SHALL be rs1_data for every supported instruction.
REQ-020 rd SHALL be instr[11:7] for every supported instruction.
REQ-021 Any other encoding (SLT/SLTU/SRA/loads/branches/etc.) SHALL be stored with illegal=1, alu_op=000, alu_a=0, alu_b=0, rd=0, and still flow through the handshake.
REQ-022 Decode SHALL be combinational on the input side; the decoded entry is captured on the cycle in_valid && in_ready.
REQ-023 Storage SHALL be a 2-entry FIFO (skid buffer) with a 2-bit count of 0..2.
REQ-024 in_ready SHALL be a registered output equal to (count<2) after each edge; it never depends combinationally on out_ready.
REQ-025 out_valid SHALL equal (count!=0), and outputs SHALL show the head entry; latency from accept to out_valid is 1 cycle when empty.
REQ-026 A pop SHALL occur when out_valid && out_ready.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-028 A push when full SHALL not occur (in_ready=0), and a pop when empty SHALL be ignored.
REQ-029 The head entry SHALL remain stable while out_valid && !out_ready.
REQ-030 Read/write pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-031 While rst_n=0 (asynchronous), count, pointers, out_valid, alu_a, alu_b, alu_op, rd and illegal SHALL all be 0.
REQ-032 in_ready SHALL be 1 while rst_n=0.
REQ-033 Reset mid-operation SHALL discard all stored entries.
REQ-034 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 Test: ADD x3,x1,x2 (0x002081B3), rs1=10, rs2=5, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=5, alu_op=000, rd=3, illegal=0.
REQ-036 Test: ADDI x1,x0,-1 (0xFFF00093), rs1=7 -> alu_a=7, alu_b=0xFFFFFFFF, alu_op=000, rd=1.
REQ-037 Test: SRLI x2,x2,4 (0x00415113) -> alu_b=4, alu_op=110; SRAI (0x40415113) -> illegal=1, alu_op=000, alu_a=0, alu_b=0.
REQ-038 Test: out_ready=0 and 3 back-to-back pushes (SUB, AND, OR) -> in_ready=0 after 2 accepts and the third is held; release out_ready -> ops emerge in order 001, 010, 011.
REQ-039 Test: count=1 with simultaneous push and pop for 10 cycles -> count stays 1, in_ready stays 1, and no entry is lost or duplicated.
REQ-040 Test: assert rst_n=0 mid-cycle with count=2 -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I register/immediate ALU instructions into
// ALU operands and an opcode, then holds them in a 2-entry skid FIFO.
// in_ready is registered, so upstream never waits on out_ready combinationally.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  typedef struct packed {
    logic        ill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } entry_t;

  entry_t           dec;
  entry_t [1:0]     mem;
  logic             wp, rp;
  logic [1:0]       cnt, cnt_nxt;
  logic             push, pop;
  logic             ok;
  logic [2:0]       op;
  logic [31:0]      opb;
  logic [2:0]       f3;
  logic [6:0]       f7;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  // Decode the incoming word; unsupported encodings become an all-zero entry flagged illegal.
  always_comb begin
    ok  = 1'b0;
    op  = OP_ADD;
    opb = '0;
    dec = '0;
    case (instr[6:0])
      7'b0110011: begin
        opb = rs2_data;
        case ({f7, f3})
          10'b0000000_000: begin ok = 1'b1; op = OP_ADD; end
          10'b0100000_000: begin ok = 1'b1; op = OP_SUB; end
          10'b0000000_111: begin ok = 1'b1; op = OP_AND; end
          10'b0000000_110: begin ok = 1'b1; op = OP_OR;  end
          10'b0000000_100: begin ok = 1'b1; op = OP_XOR; end
          10'b0000000_001: begin ok = 1'b1; op = OP_SLL; end
          10'b0000000_101: begin ok = 1'b1; op = OP_SRL; end
          default: ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        opb = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          3'b000: begin ok = 1'b1; op = OP_ADD; end
          3'b111: begin ok = 1'b1; op = OP_AND; end
          3'b110: begin ok = 1'b1; op = OP_OR;  end
          3'b100: begin ok = 1'b1; op = OP_XOR; end
          3'b001: begin ok = (f7 == 7'b0000000); op = OP_SLL; opb = {27'b0, instr[24:20]}; end
          3'b101: begin ok = (f7 == 7'b0000000); op = OP_SRL; opb = {27'b0, instr[24:20]}; end
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      dec.op = op;
      dec.a  = rs1_data;
      dec.b  = opb;
      dec.rd = instr[11:7];
    end else begin
      dec.ill = 1'b1;
    end
  end

  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign cnt_nxt   = cnt + {1'b0, push} - {1'b0, pop};

  // FIFO state; in_ready is precomputed from next-cycle occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      cnt      <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wp] <= dec;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt      <= cnt_nxt;
      in_ready <= (cnt_nxt != 2'd2);
    end
  end

  assign alu_a   = mem[rp].a;
  assign alu_b   = mem[rp].b;
  assign alu_op  = mem[rp].op;
  assign rd      = mem[rp].rd;
  assign illegal = mem[rp].ill;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: the driver queues expected entries,
// a monitor pops and compares on every output handshake.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instr, rs1_data, rs2_data;
  logic        out_valid, out_ready;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  rd;
  logic        illegal;

  typedef struct {
    logic        ill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   npop   = 0;
  int   nexp   = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Monitor: sample after the driver's negedge updates, compare the head on handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got op=%0h a=%h b=%h rd=%0d ill=%0b, none expected",
                 alu_op, alu_a, alu_b, rd, illegal);
      end else begin
        e = sb.pop_front();
        npop++;
        if ({illegal, alu_op, alu_a, alu_b, rd} !== {e.ill, e.op, e.a, e.b, e.rd}) begin
          errors++;
          $display("FAIL entry%0d got op=%0h a=%h b=%h rd=%0d ill=%0b exp op=%0h a=%h b=%h rd=%0d ill=%0b",
                   npop, alu_op, alu_a, alu_b, rd, illegal, e.op, e.a, e.b, e.rd, e.ill);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Call at a negedge; holds the request until accepted, queues its expected entry.
  task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                      input logic ill, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rdx);
    int   n;
    exp_t e;
    instr = i; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout instr=%h in_ready=%0b exp=1", i, in_ready);
    end else begin
      e.ill = ill; e.op = op; e.a = a; e.b = b; e.rd = rdx;
      sb.push_back(e);
      nexp++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic bad(input logic [31:0] i);
    send(i, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] iw;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rd", rd, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;

    // first accept right after reset release, one-cycle latency
    send(32'h002081B3, 32'd10, 32'd5, 1'b0, 3'b000, 32'd10, 32'd5, 5'd3);
    chk("latency_out_valid", out_valid, 1);

    // immediate forms
    send(32'hFFF00093, 32'd7, 32'h55, 1'b0, 3'b000, 32'd7, 32'hFFFF_FFFF, 5'd1);
    send(32'h00415113, 32'h80, 32'h55, 1'b0, 3'b110, 32'h80, 32'd4, 5'd2);
    bad(32'h40415113);
    send(32'h0F00F213, 32'hF0F0, 32'h55, 1'b0, 3'b010, 32'hF0F0, 32'h0000_00F0, 5'd4);
    send(32'hFF00E213, 32'h11, 32'h55, 1'b0, 3'b011, 32'h11, 32'hFFFF_FFF0, 5'd4);
    send(32'h7FF0C213, 32'h22, 32'h55, 1'b0, 3'b100, 32'h22, 32'h0000_07FF, 5'd4);
    send(32'h01F09213, 32'h33, 32'h55, 1'b0, 3'b101, 32'h33, 32'd31, 5'd4);
    bad(32'h02009213);
    // register forms
    send(32'h407302B3, 32'hF0, 32'h0C, 1'b0, 3'b001, 32'hF0, 32'h0C, 5'd5);
    send(32'h007372B3, 32'hF0, 32'h0C, 1'b0, 3'b010, 32'hF0, 32'h0C, 5'd5);
    send(32'h007362B3, 32'hF0, 32'h0C, 1'b0, 3'b011, 32'hF0, 32'h0C, 5'd5);
    send(32'h007342B3, 32'hF0, 32'h0C, 1'b0, 3'b100, 32'hF0, 32'h0C, 5'd5);
    send(32'h007312B3, 32'hF0, 32'h0C, 1'b0, 3'b101, 32'hF0, 32'h0C, 5'd5);
    send(32'h007352B3, 32'hF0, 32'h0C, 1'b0, 3'b110, 32'hF0, 32'h0C, 5'd5);
    bad(32'h407352B3);
    bad(32'h007322B3);
    bad(32'h022081B3);
    bad(32'h00012083);
    drain();

    // backpressure: two accepts fill the FIFO, third is held
    out_ready = 1'b0;
    send(32'h407302B3, 32'hA1, 32'hB1, 1'b0, 3'b001, 32'hA1, 32'hB1, 5'd5);
    send(32'h007372B3, 32'hA2, 32'hB2, 1'b0, 3'b010, 32'hA2, 32'hB2, 5'd5);
    chk("full_in_ready", in_ready, 0);
    instr = 32'h007362B3; rs1_data = 32'hA3; rs2_data = 32'hB3; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_in_ready", in_ready, 0);
      chk("held_head_op", alu_op, 3'b001);
      chk("held_head_a", alu_a, 32'hA1);
    end
    out_ready = 1'b1;
    send(32'h007362B3, 32'hA3, 32'hB3, 1'b0, 3'b011, 32'hA3, 32'hB3, 5'd5);
    drain();

    // steady state at count=1 with push and pop every cycle
    out_ready = 1'b0;
    send(32'h00000093, 32'h99, 32'h0, 1'b0, 3'b000, 32'h99, 32'h0, 5'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iw = (32'(i) << 20) | (32'(i + 2) << 7) | 32'h13;
      send(iw, 32'(i * 3), 32'h0, 1'b0, 3'b000, 32'(i * 3), 32'(i), 5'(i + 2));
      chk("steady_in_ready", in_ready, 1);
      chk("steady_out_valid", out_valid, 1);
    end
    drain();

    // asynchronous reset with a full FIFO
    out_ready = 1'b0;
    send(32'h007342B3, 32'hC1, 32'hD1, 1'b0, 3'b100, 32'hC1, 32'hD1, 5'd5);
    send(32'h007312B3, 32'hC2, 32'hD2, 1'b0, 3'b101, 32'hC2, 32'hD2, 5'd5);
    chk("prerst_out_valid", out_valid, 1);
    chk("prerst_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_alu_a", alu_a, 0);
    chk("async_alu_op", alu_op, 0);
    chk("async_rd", rd, 0);
    nexp = nexp - sb.size();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h002081B3, 32'd21, 32'd4, 1'b0, 3'b000, 32'd21, 32'd4, 5'd3);
    chk("postrst_out_valid", out_valid, 1);
    drain();
    repeat (3) @(negedge clk);
    chk("pop_total", npop, nexp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
